ac_motor_vector_sequencer: RTL

Sequencer for the space-vector PWM datapath. Each sampling period it advances the electrical angle and sector, and presents the in-sector angle to the sine ROM, whose outputs feed the vector-time block. It then captures the returned T_LOW/T_HIGH and plays the resulting switching pattern on the three inverter half-bridges over the next sampling period. It sits between the motor speed command and the gate-driver/dead-time stage.

---
 rtl/ac_motor_vector_pkg.sv | 46 ++++
 rtl/ac_motor_vector_phase_acc.sv | 30 +++
 rtl/ac_motor_vector_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/ac_motor_vector_pkg.sv
// ac_motor_vector_pkg: shared constants, vector table and segment encoding for the SVPWM sequencer
package ac_motor_vector_pkg;

    localparam int BITS       = 12;
    localparam int F_CLK      = 100_000_000;
    localparam int F_TAST     = 5_000;
    localparam int T_TAST_DEF = F_CLK / F_TAST;

    // Active vectors per sector as high-side states {A,B,C}; entry 0 is 100
    localparam logic [5:0][2:0] VEC = {3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        Z0   = 3'd1,
        VA   = 3'd2,
        VB   = 3'd3,
        Z7   = 3'd4
    } seg_t;

    // Segment lengths are ordered {Z7, VB, VA, Z0}; a bit per non-empty segment
    function automatic logic [3:0] nonzero(input logic [3:0][15:0] lens);
        logic [3:0] nz;
        for (int i = 0; i < 4; i++) nz[i] = lens[i] != 16'd0;
        return nz;
    endfunction

    // First non-empty segment at or after index 'from' (0 = Z0); IDLE when none is left
    function automatic seg_t next_seg(input logic [3:0] nz, input int from);
        seg_t r;
        r = IDLE;
        for (int i = 3; i >= 0; i--)
            if (nz[i] && i >= from) r = seg_t'(3'(i + 1));
        return r;
    endfunction

    function automatic logic [15:0] seg_len(input seg_t s, input logic [3:0][15:0] lens);
        return (s == IDLE) ? 16'd0 : lens[2'(3'(s) - 3'd1)];
    endfunction

    function automatic logic [2:0] seg_gate(input seg_t s, input logic [2:0] sec);
        return (s == VA) ? VEC[sec] :
               (s == VB) ? VEC[(sec == 3'd5) ? 3'd0 : sec + 3'd1] :
               (s == Z7) ? 3'b111 : 3'b000;
    endfunction

endpackage

// File: rtl/ac_motor_vector_phase_acc.sv
// ac_motor_vector_phase_acc: in-sector angle accumulator with 0..5 sector counter
module ac_motor_vector_phase_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] step,
    input  logic        advance,
    input  logic        hold,
    output logic [15:0] angle,
    output logic [15:0] angle_neg,
    output logic [2:0]  sector
);

    logic [16:0] sum;

    assign sum = {1'b0, angle} + {1'b0, step};

    // Advance once per period unless held; a carry past 60 degrees moves to the next sector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            angle     <= 16'h0000;
            angle_neg <= 16'hFFFF;
            sector    <= 3'd0;
        end else if (advance && !hold) begin
            angle     <= sum[15:0];
            angle_neg <= ~sum[15:0];
            if (sum[16]) sector <= (sector == 3'd5) ? 3'd0 : sector + 3'd1;
        end
    end

endmodule

// File: rtl/ac_motor_vector_sequencer.sv
// ac_motor_vector_sequencer: per-period angle advance, vector-time capture and half-bridge pattern playback
module ac_motor_vector_sequencer
    import ac_motor_vector_pkg::*;
#(
    parameter int T_TAST  = T_TAST_DEF,
    parameter int LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [15:0] PHASE_STEP,
    input  logic [14:0] T_LOW,
    input  logic [14:0] T_HIGH,
    output logic [15:0] ANGLE,
    output logic [15:0] ANGLE_NEG,
    output logic [2:0]  SECTOR,
    output logic        SAMPLE_TICK,
    output logic [2:0]  GATE,
    output logic        SAT
);

    localparam logic [15:0] TT  = 16'(T_TAST);
    localparam logic [15:0] LAT = 16'(LATENCY);

    logic [15:0]      cnt;
    logic             boundary;
    logic             run;
    logic [15:0]      t_low, t_high, ta, tb, t0;
    logic             sat_lo, sat_sum;
    logic [3:0][15:0] shadow_len, active_len, sel_len;
    logic [2:0]       shadow_sector, active_sector, sel_sector;
    logic             shadow_sat, shadow_valid;
    seg_t             state, nxt;
    logic [15:0]      rem;
    logic             load;

    assign boundary = cnt == 16'd0;
    assign t_low    = {1'b0, T_LOW};
    assign t_high   = {1'b0, T_HIGH};

    ac_motor_vector_phase_acc u_acc (
        .clk       (CLK),
        .rst       (RESET),
        .step      (PHASE_STEP),
        .advance   (boundary),
        .hold      (!ENABLE),
        .angle     (ANGLE),
        .angle_neg (ANGLE_NEG),
        .sector    (SECTOR)
    );

    // Clip the returned times so Z0+VA+VB+Z7 always fills exactly one period
    always_comb begin
        sat_lo  = t_low >= TT;
        sat_sum = !sat_lo && (t_low + t_high > TT);
        ta      = sat_lo ? TT : t_low;
        tb      = sat_lo ? 16'd0 : sat_sum ? TT - t_low : t_high;
        t0      = TT - ta - tb;
    end

    // Restart from the shadow times at each boundary, otherwise step past a finished segment
    always_comb begin
        sel_len    = boundary ? shadow_len : active_len;
        sel_sector = boundary ? shadow_sector : active_sector;
        load       = boundary || (state != IDLE && rem == 16'd0);
        nxt        = boundary ? ((ENABLE && shadow_valid) ? next_seg(nonzero(shadow_len), 0) : IDLE)
                   : load ? next_seg(nonzero(active_len), int'(state)) : state;
    end

    // Period counter, capture/apply of vector times and segment FSM with registered gate outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt           <= 16'd0;
            SAMPLE_TICK   <= 1'b0;
            run           <= 1'b0;
            SAT           <= 1'b0;
            GATE          <= 3'b000;
            state         <= IDLE;
            rem           <= 16'd0;
            shadow_len    <= '0;
            active_len    <= '0;
            shadow_sector <= 3'd0;
            active_sector <= 3'd0;
            shadow_sat    <= 1'b0;
            shadow_valid  <= 1'b0;
        end else begin
            cnt         <= (cnt == TT - 16'd1) ? 16'd0 : cnt + 16'd1;
            SAMPLE_TICK <= boundary;
            state       <= nxt;
            GATE        <= seg_gate(nxt, sel_sector);
            if (load) rem <= seg_len(nxt, sel_len) - 16'd1;
            else if (rem != 16'd0) rem <= rem - 16'd1;
            if (boundary) begin
                run           <= ENABLE;
                SAT           <= ENABLE && shadow_valid && shadow_sat;
                active_len    <= shadow_len;
                active_sector <= shadow_sector;
            end
            if (cnt == LAT) begin
                shadow_len    <= {t0 - (t0 >> 1), tb, ta, t0 >> 1};
                shadow_sector <= SECTOR;
                shadow_sat    <= sat_lo || sat_sum;
                shadow_valid  <= run;
            end
        end
    end

endmodule
